// File: rtl/load_align_unit_pkg.sv
// Shared opcodes, FSM state type and byte-swap helper for the load alignment unit.
package load_align_unit_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OPCODE_LB  = 6'h20;
  localparam logic [OPCODE_W-1:0] OPCODE_LH  = 6'h21;
  localparam logic [OPCODE_W-1:0] OPCODE_LWL = 6'h22;
  localparam logic [OPCODE_W-1:0] OPCODE_LW  = 6'h23;
  localparam logic [OPCODE_W-1:0] OPCODE_LBU = 6'h24;
  localparam logic [OPCODE_W-1:0] OPCODE_LHU = 6'h25;
  localparam logic [OPCODE_W-1:0] OPCODE_LWR = 6'h26;

  typedef enum logic [1:0] {
    LA_IDLE     = 2'd0,
    LA_WAIT_MEM = 2'd1,
    LA_HOLD     = 2'd2
  } load_align_state_t;

  function automatic logic [WORD_W-1:0] byte_swap32(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/load_align_unit_extract.sv
// Combinational lane select / extend / merge for MIPS loads, plus legality check.
module load_extract
  import load_align_unit_pkg::*;
(
  input  logic [WORD_W-1:0]   word_i,
  input  logic [WORD_W-1:0]   rt_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [1:0]          lsb_i,
  output logic [WORD_W-1:0]   data_c,
  output logic                misaligned_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [4:0]  shl_c;
  logic [4:0]  shr_c;

  // LWL shifts by 8*(3-k) == 8*~k for a 2-bit k; LWR shifts by 8*k.
  always_comb begin
    shl_c  = {~lsb_i, 3'b000};
    shr_c  = {lsb_i, 3'b000};
    byte_c = 8'(word_i >> shr_c);
    half_c = lsb_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_c       = rt_i;
    misaligned_c = 1'b0;
    case (opcode_i)
      OPCODE_LB:  data_c = {{24{byte_c[7]}}, byte_c};
      OPCODE_LBU: data_c = {24'h000000, byte_c};
      OPCODE_LH: begin
        data_c       = {{16{half_c[15]}}, half_c};
        misaligned_c = lsb_i[0];
      end
      OPCODE_LHU: begin
        data_c       = {16'h0000, half_c};
        misaligned_c = lsb_i[0];
      end
      OPCODE_LW: begin
        data_c       = word_i;
        misaligned_c = (lsb_i != 2'b00);
      end
      OPCODE_LWL: data_c = (word_i << shl_c) | (rt_i & ~(32'hFFFF_FFFF << shl_c));
      OPCODE_LWR: data_c = (word_i >> shr_c) | (rt_i & ~(32'hFFFF_FFFF >> shr_c));
      default:    misaligned_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Load formatter: accepts one load, waits on memory, formats the word and holds it for writeback.
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter bit          BYTE_SWAP = 1'b0,
  parameter int unsigned DEST_W    = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [OPCODE_W-1:0] issue_opcode,
  input  logic [1:0]          issue_addr_lsb,
  input  logic [WORD_W-1:0]   issue_rt_val,
  input  logic [DEST_W-1:0]   issue_dest,
  output logic                mem_read,
  input  logic                mem_waitrequest,
  input  logic [WORD_W-1:0]   mem_readdata,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [WORD_W-1:0]   wb_data,
  output logic [DEST_W-1:0]   wb_dest,
  output logic                wb_err
);

  load_align_state_t   state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [1:0]          lsb_q, lsb_d;
  logic [WORD_W-1:0]   rt_q, rt_d;
  logic [WORD_W-1:0]   wb_data_q, wb_data_d;
  logic [DEST_W-1:0]   wb_dest_q, wb_dest_d;
  logic                wb_err_q, wb_err_d;
  logic                issue_ready_q, issue_ready_d;
  logic                mem_read_q, mem_read_d;
  logic                wb_valid_q, wb_valid_d;

  logic [WORD_W-1:0]   word_c;
  logic [OPCODE_W-1:0] ext_op_c;
  logic [1:0]          ext_lsb_c;
  logic [WORD_W-1:0]   ext_data_c;
  logic                ext_mis_c;

  // The single extractor sees the live request in IDLE and the captured one afterwards.
  always_comb begin
    word_c    = BYTE_SWAP ? byte_swap32(mem_readdata) : mem_readdata;
    ext_op_c  = (state_q == LA_IDLE) ? issue_opcode   : op_q;
    ext_lsb_c = (state_q == LA_IDLE) ? issue_addr_lsb : lsb_q;
  end

  load_extract u_extract (
    .word_i       (word_c),
    .rt_i         (rt_q),
    .opcode_i     (ext_op_c),
    .lsb_i        (ext_lsb_c),
    .data_c       (ext_data_c),
    .misaligned_c (ext_mis_c)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    lsb_d     = lsb_q;
    rt_d      = rt_q;
    wb_data_d = wb_data_q;
    wb_dest_d = wb_dest_q;
    wb_err_d  = wb_err_q;
    case (state_q)
      LA_IDLE: begin
        if (issue_valid && issue_ready_q) begin
          op_d      = issue_opcode;
          lsb_d     = issue_addr_lsb;
          rt_d      = issue_rt_val;
          wb_dest_d = issue_dest;
          if (ext_mis_c) begin
            // Bad accesses skip memory and return rt unchanged with the error flag.
            wb_err_d  = 1'b1;
            wb_data_d = issue_rt_val;
            state_d   = LA_HOLD;
          end else begin
            state_d = LA_WAIT_MEM;
          end
        end
      end
      LA_WAIT_MEM: begin
        if (!mem_waitrequest) begin
          wb_data_d = ext_data_c;
          wb_err_d  = 1'b0;
          state_d   = LA_HOLD;
        end
      end
      LA_HOLD: begin
        if (wb_ready) state_d = LA_IDLE;
      end
      default: state_d = LA_IDLE;
    endcase
    issue_ready_d = (state_d == LA_IDLE);
    mem_read_d    = (state_d == LA_WAIT_MEM);
    wb_valid_d    = (state_d == LA_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= LA_IDLE;
      op_q          <= '0;
      lsb_q         <= '0;
      rt_q          <= '0;
      wb_data_q     <= '0;
      wb_dest_q     <= '0;
      wb_err_q      <= 1'b0;
      issue_ready_q <= 1'b0;
      mem_read_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      lsb_q         <= lsb_d;
      rt_q          <= rt_d;
      wb_data_q     <= wb_data_d;
      wb_dest_q     <= wb_dest_d;
      wb_err_q      <= wb_err_d;
      issue_ready_q <= issue_ready_d;
      mem_read_q    <= mem_read_d;
      wb_valid_q    <= wb_valid_d;
    end
  end

  assign issue_ready = issue_ready_q;
  assign mem_read    = mem_read_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_dest     = wb_dest_q;
  assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: raw-lane instance plus a byte-swapped instance.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        issue_valid, issue_ready;
  logic [5:0]  issue_opcode;
  logic [1:0]  issue_addr_lsb;
  logic [31:0] issue_rt_val;
  logic [4:0]  issue_dest;
  logic        mem_read, mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        wb_valid, wb_ready, wb_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;

  logic        s_issue_valid, s_issue_ready;
  logic [5:0]  s_issue_opcode;
  logic [1:0]  s_issue_addr_lsb;
  logic [31:0] s_issue_rt_val;
  logic [4:0]  s_issue_dest;
  logic        s_mem_read, s_mem_waitrequest;
  logic [31:0] s_mem_readdata;
  logic        s_wb_valid, s_wb_ready, s_wb_err;
  logic [31:0] s_wb_data;
  logic [4:0]  s_wb_dest;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_align_unit #(.BYTE_SWAP(1'b0), .DEST_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_addr_lsb(issue_addr_lsb),
    .issue_rt_val(issue_rt_val), .issue_dest(issue_dest),
    .mem_read(mem_read), .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_dest(wb_dest), .wb_err(wb_err)
  );

  load_align_unit #(.BYTE_SWAP(1'b1), .DEST_W(5)) dut_swap (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(s_issue_valid), .issue_ready(s_issue_ready),
    .issue_opcode(s_issue_opcode), .issue_addr_lsb(s_issue_addr_lsb),
    .issue_rt_val(s_issue_rt_val), .issue_dest(s_issue_dest),
    .mem_read(s_mem_read), .mem_waitrequest(s_mem_waitrequest), .mem_readdata(s_mem_readdata),
    .wb_valid(s_wb_valid), .wb_ready(s_wb_ready), .wb_data(s_wb_data),
    .wb_dest(s_wb_dest), .wb_err(s_wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one load, stall memory for `waits` cycles, hold writeback for `hold` cycles, then retire.
  task automatic do_load(input string tag, input logic [5:0] op, input logic [1:0] lsb,
                         input logic [31:0] rt, input logic [31:0] rd, input int waits,
                         input int hold, input logic [4:0] dest,
                         input logic [31:0] exp_data, input logic exp_err);
    int c;
    int rd_cycles;
    c = 0;
    rd_cycles = 0;
    chk({tag, ".ready"}, 32'(issue_ready), 32'd1);
    mem_readdata    = rd;
    mem_waitrequest = 1'b1;
    issue_opcode    = op;
    issue_addr_lsb  = lsb;
    issue_rt_val    = rt;
    issue_dest      = dest;
    issue_valid     = 1'b1;
    tick();
    issue_valid = 1'b0;
    while (c < 20) begin
      if (wb_valid) break;
      c++;
      if (mem_read) rd_cycles++;
      mem_waitrequest = (c <= waits);
      tick();
    end
    mem_readdata    = 32'h5A5A_A5A5;
    mem_waitrequest = 1'b0;
    chk({tag, ".valid"}, 32'(wb_valid), 32'd1);
    chk({tag, ".rdcyc"}, 32'(rd_cycles), exp_err ? 32'd0 : 32'(waits + 1));
    chk({tag, ".data"}, wb_data, exp_data);
    chk({tag, ".err"}, 32'(wb_err), 32'(exp_err));
    chk({tag, ".dest"}, 32'(wb_dest), 32'(dest));
    for (int h = 0; h < hold; h++) begin
      issue_opcode   = 6'h23;
      issue_addr_lsb = 2'b00;
      issue_rt_val   = 32'h0BAD_0BAD;
      issue_dest     = ~dest;
      issue_valid    = 1'b1;
      tick();
      chk({tag, ".hold_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(issue_ready), 32'd0);
      chk({tag, ".hold_rd"}, 32'(mem_read), 32'd0);
      chk({tag, ".hold_data"}, wb_data, exp_data);
      chk({tag, ".hold_dest"}, 32'(wb_dest), 32'(dest));
    end
    issue_valid = 1'b0;
    wb_ready    = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk({tag, ".retire"}, 32'(wb_valid), 32'd0);
    chk({tag, ".idle"}, 32'(issue_ready), 32'd1);
  endtask

  initial begin
    int c;
    reset_n = 1'b0;
    issue_valid = 1'b0; issue_opcode = '0; issue_addr_lsb = '0; issue_rt_val = '0; issue_dest = '0;
    mem_waitrequest = 1'b0; mem_readdata = '0; wb_ready = 1'b0;
    s_issue_valid = 1'b0; s_issue_opcode = '0; s_issue_addr_lsb = '0; s_issue_rt_val = '0;
    s_issue_dest = '0; s_mem_waitrequest = 1'b0; s_mem_readdata = '0; s_wb_ready = 1'b0;

    tick();
    tick();
    chk("rst.ready", 32'(issue_ready), 32'd0);
    chk("rst.rd", 32'(mem_read), 32'd0);
    chk("rst.valid", 32'(wb_valid), 32'd0);
    chk("rst.data", wb_data, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst.ready", 32'(issue_ready), 32'd1);

    do_load("lb",   6'h20, 2'd1, 32'h0,         32'h0000_8000, 0, 0, 5'd1,  32'hFFFF_FF80, 1'b0);
    do_load("lbu",  6'h24, 2'd1, 32'h0,         32'h0000_8000, 0, 0, 5'd2,  32'h0000_0080, 1'b0);
    do_load("lb3",  6'h20, 2'd3, 32'h0,         32'h7F00_0000, 0, 0, 5'd3,  32'h0000_007F, 1'b0);
    do_load("lh",   6'h21, 2'd2, 32'h0,         32'h9ABC_1234, 3, 0, 5'd4,  32'hFFFF_9ABC, 1'b0);
    do_load("lhu",  6'h25, 2'd2, 32'h0,         32'h9ABC_1234, 3, 0, 5'd5,  32'h0000_9ABC, 1'b0);
    do_load("lh0",  6'h21, 2'd0, 32'h0,         32'h9ABC_8234, 0, 0, 5'd6,  32'hFFFF_8234, 1'b0);
    do_load("lwl1", 6'h22, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 5'd7,  32'h3344_CCDD, 1'b0);
    do_load("lwr1", 6'h26, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 5'd8,  32'hAA11_2233, 1'b0);
    do_load("lwl0", 6'h22, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 5'd9,  32'h44BB_CCDD, 1'b0);
    do_load("lwl3", 6'h22, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 5'd10, 32'h1122_3344, 1'b0);
    do_load("lwr3", 6'h26, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 5'd11, 32'hAABB_CC11, 1'b0);
    do_load("lw",   6'h23, 2'd0, 32'h0,         32'hDEAD_BEEF, 1, 0, 5'd12, 32'hDEAD_BEEF, 1'b0);
    do_load("lw_mis", 6'h23, 2'd2, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 5'd13, 32'h1234_5678, 1'b1);
    do_load("lh_mis", 6'h21, 2'd1, 32'h0F0F_0F0F, 32'hDEAD_BEEF, 0, 0, 5'd14, 32'h0F0F_0F0F, 1'b1);
    do_load("sw",   6'h2B, 2'd0, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0, 0, 5'd15, 32'hCAFE_F00D, 1'b1);
    do_load("hold", 6'h20, 2'd0, 32'h0,         32'h0000_00C3, 0, 5, 5'd16, 32'hFFFF_FFC3, 1'b0);
    do_load("after_hold", 6'h24, 2'd0, 32'h0,   32'h0000_00C3, 0, 0, 5'd17, 32'h0000_00C3, 1'b0);

    // Reset during a memory stall drops the load.
    mem_waitrequest = 1'b1;
    issue_opcode = 6'h23; issue_addr_lsb = 2'd0; issue_rt_val = 32'h1; issue_dest = 5'd18;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    chk("mid.rd", 32'(mem_read), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst.rd", 32'(mem_read), 32'd0);
    chk("mid_rst.valid", 32'(wb_valid), 32'd0);
    chk("mid_rst.ready", 32'(issue_ready), 32'd0);
    chk("mid_rst.data", wb_data, 32'd0);
    chk("mid_rst.dest", 32'(wb_dest), 32'd0);
    chk("mid_rst.err", 32'(wb_err), 32'd0);
    reset_n = 1'b1;
    mem_waitrequest = 1'b0;
    tick();
    tick();
    chk("mid_rst.no_wb", 32'(wb_valid), 32'd0);
    chk("mid_rst.ready2", 32'(issue_ready), 32'd1);

    // Byte-swapped instance: big-endian byte 0 sits in bits [31:24] of the raw bus.
    s_mem_readdata = 32'h8000_0000;
    s_mem_waitrequest = 1'b0;
    s_issue_opcode = 6'h20; s_issue_addr_lsb = 2'd0; s_issue_rt_val = 32'h0; s_issue_dest = 5'd21;
    s_issue_valid = 1'b1;
    tick();
    s_issue_valid = 1'b0;
    c = 0;
    while (c < 20 && !s_wb_valid) begin
      c++;
      tick();
    end
    chk("swap.valid", 32'(s_wb_valid), 32'd1);
    chk("swap.data", s_wb_data, 32'hFFFF_FF80);
    chk("swap.dest", 32'(s_wb_dest), 32'd21);
    s_wb_ready = 1'b1;
    tick();
    s_wb_ready = 1'b0;
    chk("swap.retire", 32'(s_wb_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
